// File: rtl/bird_motion_controller.sv
`default_nettype none
// ============================================================================
// Module   : bird_motion_controller
// Function : Per-frame bird physics (gravity, flap, ceiling/ground clamp) and
//            game-over sequencing; drives the bird_reg word for display.
// Revision : 1.0  initial release
// ============================================================================
module bird_motion_controller #(
   parameter int SCREEN_HEIGHT = 480,
   parameter int BIRD_HEIGHT   = 35,
   parameter int GROUND_Y      = 440,
   parameter int START_Y       = 200,
   parameter int GRAVITY       = 1,
   parameter int FLAP_VEL      = 8,
   parameter int MAX_FALL      = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        frame_tick,
   input  logic        flap,
   input  logic        restart,
   input  logic        collision,
   output logic [31:0] bird_reg,
   output logic [7:0]  velocity,
   output logic [1:0]  state,
   output logic        bird_dead
);

   localparam int POS_W = $clog2(SCREEN_HEIGHT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_FLYING = 2'b01,
      ST_DYING  = 2'b10,
      ST_DEAD   = 2'b11
   } state_t;

   localparam logic [POS_W-1:0]  c_start_y    = POS_W'(START_Y);
   localparam logic [POS_W-1:0]  c_ground_pos = POS_W'(GROUND_Y - BIRD_HEIGHT);
   localparam logic signed [10:0] c_ground_sum = 11'(GROUND_Y - BIRD_HEIGHT);
   localparam logic signed [7:0] c_max_fall   = 8'(MAX_FALL);
   localparam logic signed [7:0] c_grav_limit = 8'(MAX_FALL - GRAVITY);
   localparam logic signed [7:0] c_gravity    = 8'(GRAVITY);
   localparam logic signed [7:0] c_flap_vel   = 8'(-FLAP_VEL);

   state_t             r_state;
   logic [POS_W-1:0]   r_pos;
   logic signed [7:0]  r_vel;
   logic               r_flap_meta;
   logic               r_flap_sync;
   logic               r_flap_prev;
   logic               r_flap_pending;
   logic               r_bird_dead;

   logic               w_flap_rise;
   logic               w_apply_flap;
   logic signed [7:0]  w_vel_grav;
   logic signed [7:0]  w_vel_next;
   logic signed [10:0] w_pos_sum;
   logic               w_hit_ground;
   logic [POS_W-1:0]   w_pos_new;
   logic signed [7:0]  w_vel_new;

   always_comb begin
      w_flap_rise  = r_flap_sync & ~r_flap_prev;
      w_apply_flap = r_flap_pending &
                     ((r_state == ST_IDLE) || ((r_state == ST_FLYING) && !collision));
      // Saturate before adding so the sum never leaves the 8-bit range
      w_vel_grav   = (r_vel >= c_grav_limit) ? c_max_fall : (r_vel + c_gravity);
      w_vel_next   = w_apply_flap ? c_flap_vel : w_vel_grav;
      w_pos_sum    = $signed({{(11-POS_W){1'b0}}, r_pos}) +
                     $signed({{3{w_vel_next[7]}}, w_vel_next});
      w_hit_ground = (w_pos_sum >= c_ground_sum);
      w_pos_new    = w_pos_sum[POS_W-1:0];
      w_vel_new    = w_vel_next;
      if (w_pos_sum < 11'sd0) begin
         w_pos_new = '0;
         w_vel_new = '0;
      end else if (w_hit_ground) begin
         w_pos_new = c_ground_pos;
         w_vel_new = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= ST_IDLE;
         r_pos          <= c_start_y;
         r_vel          <= '0;
         r_flap_meta    <= 1'b0;
         r_flap_sync    <= 1'b0;
         r_flap_prev    <= 1'b0;
         r_flap_pending <= 1'b0;
         r_bird_dead    <= 1'b0;
      end else begin
         r_flap_meta <= flap;
         r_flap_sync <= r_flap_meta;
         r_flap_prev <= r_flap_sync;

         if ((r_state == ST_DEAD) && restart) begin
            r_state        <= ST_IDLE;
            r_pos          <= c_start_y;
            r_vel          <= '0;
            r_flap_pending <= 1'b0;
            r_bird_dead    <= 1'b0;
         end else if (frame_tick) begin
            // An edge arriving with the tick survives only if it is not merged into a flap being consumed
            r_flap_pending <= w_flap_rise & ~r_flap_pending;
            case (r_state)
               ST_IDLE: begin
                  if (r_flap_pending) begin
                     r_state <= ST_FLYING;
                     r_pos   <= w_pos_new;
                     r_vel   <= w_vel_new;
                  end
               end
               ST_FLYING, ST_DYING: begin
                  r_pos <= w_pos_new;
                  r_vel <= w_vel_new;
                  if (w_hit_ground) begin
                     r_state     <= ST_DEAD;
                     r_bird_dead <= 1'b1;
                  end else if ((r_state == ST_FLYING) && collision) begin
                     r_state     <= ST_DYING;
                     r_bird_dead <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end else begin
            r_flap_pending <= r_flap_pending | w_flap_rise;
         end
      end
   end

   assign bird_reg  = {{(32-POS_W){1'b0}}, r_pos};
   assign velocity  = r_vel;
   assign state     = r_state;
   assign bird_dead = r_bird_dead;

endmodule
`default_nettype wire

// File: doc/bird_motion_controller.md
# bird_motion_controller

Per-frame physics sequencer for the bird sprite. Owns the bird's vertical position and velocity, applies gravity and flap impulses once per video frame, runs the game-over sequence, and drives the 32-bit `bird_reg` word consumed by the bird display stage. Sits between the input controller (flap/restart buttons, collision flag) and the VGA output path. Updates only on the frame tick, so the display never sees a mid-frame position change.

## Interface

Parameters:
- SCREEN_HEIGHT, 480, visible lines
- BIRD_HEIGHT, 35, sprite height in lines
- GROUND_Y, 440, first line of ground; bird top edge max = GROUND_Y - BIRD_HEIGHT (405)
- START_Y, 200, top edge in IDLE and after restart
- GRAVITY, 1, velocity increment per frame (lines/frame)
- FLAP_VEL, 8, magnitude of upward velocity set by a flap
- MAX_FALL, 10, downward velocity cap

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame, asserted during vertical blanking
- flap  in  1  raw flap button level (asynchronous)
- restart  in  1  one-cycle restart request
- collision  in  1  level, bird overlaps a pipe (sampled only on frame_tick)
- bird_reg  out  32  [8:0] = bird top edge, [31:9] = 0
- velocity  out  8  signed current velocity (positive = down)
- state  out  2  00 IDLE, 01 FLYING, 10 DYING, 11 DEAD
- bird_dead  out  1  high in DYING or DEAD

## Operation

- Reset (any time, including mid-frame or mid-update): state IDLE, position START_Y, velocity 0, flap pending cleared, synchroniser cleared, bird_dead 0.
- flap passes through a 2-flop synchroniser; a rising edge of the synchronised level sets `flap_pending`. The flag is cleared when a frame_tick consumes it. Multiple edges within one frame collapse to one flap.
- All state/position/velocity changes occur only on cycles with frame_tick = 1; other cycles hold.
- IDLE: position and velocity held. On tick with flap_pending → FLYING, apply flap update this tick.
- FLYING, on tick:
  - collision = 1 → DYING, discard flap_pending, apply gravity update this tick (collision beats flap).
  - else vel_next = flap_pending ? -FLAP_VEL : min(vel + GRAVITY, MAX_FALL).
  - pos_next = pos + vel_next (new velocity applied in same tick), computed in signed 11-bit.
  - pos_next < 0 → pos 0, vel 0 (ceiling).
  - pos_next ≥ GROUND_Y - BIRD_HEIGHT → pos = GROUND_Y - BIRD_HEIGHT, vel 0, → DEAD.
- DYING: flap_pending cleared and ignored each tick; gravity update with caps; on reaching ground → DEAD (same clamp).
- DEAD: everything held. restart = 1 → IDLE, position START_Y, velocity 0, pending cleared.
- restart in IDLE/FLYING/DYING: ignored.
- restart and frame_tick on same cycle in DEAD: restart wins; no physics on that tick.

## Timing

- Outputs registered; bird_reg, velocity, state update on the clock edge that samples frame_tick (visible the next cycle).
- Flap latency: button edge to flap_pending = 3 cycles (2 sync + edge detect); an edge whose pending flag is set on the same cycle as frame_tick is not seen until the following tick.
- Rising edge detected on the synchronised level in the same cycle as frame_tick: consumed by that tick only if flap_pending was already set; otherwise held for the next tick (no loss).
- Reset values: bird_reg = START_Y (200), velocity 0, state 00, bird_dead 0.

## Test plan

- Reset: assert reset_n=0 mid-frame with bird at 300 → bird_reg=200, velocity 0, state IDLE immediately (asynchronous).
- Start flap: flap pulse then tick → state FLYING, velocity -8, bird_reg 192; three more ticks without flap → 185, 179, 174 (velocity -7, -6, -5).
- Free fall and ground: from FLYING at 200, velocity 0, tick repeatedly → velocity caps at 10; bird_reg clamps at 405, velocity 0, state DEAD, bird_dead=1; further ticks hold.
- Ceiling: bird_reg 4, velocity -2, flap pending on tick → bird_reg 0, velocity 0, state FLYING.
- Collision priority: collision=1 and flap pending on same tick at 250, velocity 3 → state DYING, velocity 4, bird_reg 254; subsequent flaps have no effect.
- Restart: in DEAD, restart and frame_tick same cycle → IDLE, bird_reg 200, velocity 0; no physics applied.
